// File: rtl/test_aggregator_pkg.sv
// Shared types and helpers for the test aggregator and its priority encoder.
package test_aggregator_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_PASS,
      ST_FAIL,
      ST_TMO
   } state_e;

   typedef enum logic [1:0] {
      VD_NONE,
      VD_PASS,
      VD_FAIL,
      VD_TMO
   } verdict_e;

   // A single channel still needs a one-bit index port.
   function automatic int ffi_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/test_aggregator_prio_enc.sv
// prio_enc_lsb: index of the lowest set bit of in_vec, with a valid flag when any bit is set.
module prio_enc_lsb
   import test_aggregator_pkg::*;
#(
   parameter int W     = 3,
   parameter int IDX_W = ffi_width(W)
) (
   input  logic [W-1:0]     in_vec,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      for (int i = W - 1; i >= 0; i--) begin
         if (in_vec[i]) idx = IDX_W'(i);
      end
   end

   assign valid = |in_vec;

endmodule

// File: rtl/test_aggregator.sv
// test_aggregator: folds per-channel ready/error reports into one registered verdict.
// Build option TEST_AGGREGATOR_WATCHDOG_EN enables the RUN watchdog and the TMO verdict.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | collecting ready/error, counting cycles
// PASS  | every channel reported ready, none failed
// FAIL  | at least one channel reported an error
// TMO   | watchdog expired before any other verdict
module test_aggregator
   import test_aggregator_pkg::*;
#(
   parameter int NUM_CH         = 3,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int CNT_W          = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         clear,
   input  logic [NUM_CH-1:0]            ready,
   input  logic [NUM_CH-1:0]            error,
   output logic                         done,
   output logic                         pass,
   output logic                         fail,
   output logic                         timeout,
   output logic [NUM_CH-1:0]            fail_mask,
   output logic [ffi_width(NUM_CH)-1:0] first_fail_idx,
   output logic [CNT_W-1:0]             cycle_count
);

   localparam int IDX_W = ffi_width(NUM_CH);

   if (NUM_CH < 1 || NUM_CH > 32 || TIMEOUT_CYCLES < 2) begin : g_bad_param
      $error("test_aggregator: NUM_CH must be 1..32 and TIMEOUT_CYCLES at least 2");
   end

   state_e              state_q, state_d;
   verdict_e            verdict;
   logic                done_q, done_d;
   logic [NUM_CH-1:0]   ready_seen_q, ready_seen_d;
   logic [NUM_CH-1:0]   fail_mask_q, fail_mask_d;
   logic [IDX_W-1:0]    ffi_q, ffi_d;
   logic [IDX_W-1:0]    err_idx;
   logic                err_any;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                all_ready;
   logic                wdog_tc;

   prio_enc_lsb #(
      .W     (NUM_CH),
      .IDX_W (IDX_W)
   ) u_err_enc (
      .in_vec (error),
      .idx    (err_idx),
      .valid  (err_any)
   );

   assign all_ready = &(ready_seen_q | ready);

`ifdef TEST_AGGREGATOR_WATCHDOG_EN
   // Down-counter reaches terminal count on the RUN cycle where cycle_count == TIMEOUT_CYCLES-1.
   localparam logic [CNT_W-1:0] WDOG_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] wdog_q, wdog_d;
   assign wdog_tc = (wdog_q == '0);
`else
   assign wdog_tc = 1'b0;
`endif

   always_comb begin
      verdict = VD_NONE;
      if (err_any)        verdict = VD_FAIL;
      else if (all_ready) verdict = VD_PASS;
      else if (wdog_tc)   verdict = VD_TMO;
   end

   always_comb begin
      state_d      = state_q;
      done_d       = 1'b0;
      ready_seen_d = ready_seen_q;
      fail_mask_d  = fail_mask_q;
      ffi_d        = ffi_q;
      cnt_d        = cnt_q;
`ifdef TEST_AGGREGATOR_WATCHDOG_EN
      wdog_d       = wdog_q;
`endif
      if (clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d      = ST_RUN;
                  ready_seen_d = '0;
                  fail_mask_d  = '0;
                  ffi_d        = '0;
                  cnt_d        = '0;
`ifdef TEST_AGGREGATOR_WATCHDOG_EN
                  wdog_d       = WDOG_LOAD;
`endif
               end
            end
            ST_RUN: begin
               ready_seen_d = ready_seen_q | ready;
               fail_mask_d  = fail_mask_q | error;
               if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
`ifdef TEST_AGGREGATOR_WATCHDOG_EN
               if (!wdog_tc) wdog_d = wdog_q - CNT_W'(1);
`endif
               case (verdict)
                  VD_FAIL: begin
                     state_d = ST_FAIL;
                     ffi_d   = err_idx;
                     done_d  = 1'b1;
                  end
                  VD_PASS: begin
                     state_d = ST_PASS;
                     done_d  = 1'b1;
                  end
                  VD_TMO: begin
                     state_d = ST_TMO;
                     done_d  = 1'b1;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         done_q       <= 1'b0;
         ready_seen_q <= '0;
         fail_mask_q  <= '0;
         ffi_q        <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         done_q       <= done_d;
         ready_seen_q <= ready_seen_d;
         fail_mask_q  <= fail_mask_d;
         ffi_q        <= ffi_d;
         cnt_q        <= cnt_d;
      end
   end

`ifdef TEST_AGGREGATOR_WATCHDOG_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) wdog_q <= '0;
      else        wdog_q <= wdog_d;
   end

   assign timeout = (state_q == ST_TMO);
`else
   assign timeout = 1'b0;
`endif

   assign done           = done_q;
   assign pass           = (state_q == ST_PASS);
   assign fail           = (state_q == ST_FAIL);
   assign fail_mask      = fail_mask_q;
   assign first_fail_idx = ffi_q;
   assign cycle_count    = cnt_q;

endmodule

// File: tb/tb_test_aggregator.sv
// Bench for test_aggregator: directed scenarios plus random traffic against a behavioural model.
module tb_test_aggregator;

   localparam int NUM_CH  = 3;
   localparam int TMO     = 16;
   localparam int CNT_W   = 5;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

`ifdef TEST_AGGREGATOR_WATCHDOG_EN
   localparam bit WDOG_EN = 1'b1;
`else
   localparam bit WDOG_EN = 1'b0;
`endif

   logic              clk   = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              clear = 1'b0;
   logic [NUM_CH-1:0] ready = '0;
   logic [NUM_CH-1:0] error = '0;
   logic              done, pass, fail, timeout;
   logic [NUM_CH-1:0] fail_mask;
   logic [1:0]        first_fail_idx;
   logic [CNT_W-1:0]  cycle_count;

   int n_cmp  = 0;
   int n_bad  = 0;
   bit chk_en = 1'b0;

   test_aggregator #(
      .NUM_CH         (NUM_CH),
      .TIMEOUT_CYCLES (TMO),
      .CNT_W          (CNT_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .clear          (clear),
      .ready          (ready),
      .error          (error),
      .done           (done),
      .pass           (pass),
      .fail           (fail),
      .timeout        (timeout),
      .fail_mask      (fail_mask),
      .first_fail_idx (first_fail_idx),
      .cycle_count    (cycle_count)
   );

   always #5 clk = ~clk;

   // Behavioural model: run phase, verdict, and an unbounded count of RUN cycles.
   typedef enum int {M_IDLE, M_RUN, M_PASS, M_FAIL, M_TMO} mphase_t;
   mphase_t           m_ph     = M_IDLE;
   bit                m_done   = 1'b0;
   logic [NUM_CH-1:0] m_seen   = '0;
   logic [NUM_CH-1:0] m_mask   = '0;
   int                m_ffi    = 0;
   int                m_cycles = 0;

   function automatic int lowest_set(input logic [NUM_CH-1:0] v);
      for (int i = 0; i < NUM_CH; i++) if (v[i]) return i;
      return 0;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_ph = M_IDLE; m_done = 1'b0; m_seen = '0; m_mask = '0; m_ffi = 0; m_cycles = 0;
      end else begin
         m_done = 1'b0;
         if (clear) begin
            m_ph = M_IDLE;
         end else if (m_ph == M_IDLE && start) begin
            m_ph = M_RUN; m_seen = '0; m_mask = '0; m_ffi = 0; m_cycles = 0;
         end else if (m_ph == M_RUN) begin
            m_mask = m_mask | error;
            m_seen = m_seen | ready;
            if (error != '0) begin
               m_ph = M_FAIL; m_ffi = lowest_set(error); m_done = 1'b1;
            end else if (&m_seen) begin
               m_ph = M_PASS; m_done = 1'b1;
            end else if (WDOG_EN && m_cycles == TMO - 1) begin
               m_ph = M_TMO; m_done = 1'b1;
            end
            m_cycles = m_cycles + 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("done",    32'(done),    32'(m_done));
         chk("pass",    32'(pass),    32'(m_ph == M_PASS));
         chk("fail",    32'(fail),    32'(m_ph == M_FAIL));
         chk("timeout", 32'(timeout), 32'(m_ph == M_TMO));
         chk("fail_mask", 32'(fail_mask), 32'(m_mask));
         chk("first_fail_idx", 32'(first_fail_idx), 32'(m_ffi));
         chk("cycle_count", 32'(cycle_count), 32'((m_cycles > CNT_MAX) ? CNT_MAX : m_cycles));
      end
   end

   task automatic step(input logic s, input logic c,
                       input logic [NUM_CH-1:0] r, input logic [NUM_CH-1:0] e);
      start = s; clear = c; ready = r; error = e;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_pass"}, 32'(pass), 0);
      chk({tag, "_fail"}, 32'(fail), 0);
      chk({tag, "_timeout"}, 32'(timeout), 0);
      chk({tag, "_mask"}, 32'(fail_mask), 0);
      chk({tag, "_ffi"}, 32'(first_fail_idx), 0);
      chk({tag, "_cnt"}, 32'(cycle_count), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      reset  = 1'b1;
      chk_en = 1'b1;

      // Staggered ready pulses on ch0/ch1/ch2 at cycles 2/5/9 after start.
      step(1'b1, 1'b0, '0, '0);
      chk("run_cnt0", 32'(cycle_count), 0);
      idle(1);
      step(1'b0, 1'b0, 3'b001, '0);
      idle(2);
      step(1'b0, 1'b0, 3'b010, '0);
      idle(3);
      step(1'b0, 1'b0, 3'b100, '0);
      chk("pulse_done", 32'(done), 1);
      chk("pulse_pass", 32'(pass), 1);
      chk("pulse_mask", 32'(fail_mask), 0);
      chk("pulse_cnt", 32'(cycle_count), 9);
      idle(1);
      chk("pulse_done_1cyc", 32'(done), 0);
      chk("pulse_pass_held", 32'(pass), 1);

      // start in PASS is ignored; clear then start begins a fresh run.
      step(1'b1, 1'b0, '0, '0);
      chk("pass_start_ign", 32'(pass), 1);
      chk("pass_start_cnt", 32'(cycle_count), 9);
      step(1'b0, 1'b1, '0, '0);
      chk("clr_pass", 32'(pass), 0);
      step(1'b1, 1'b0, '0, '0);
      chk("rerun_cnt0", 32'(cycle_count), 0);
      step(1'b0, 1'b0, 3'b001, '0);
      idle(2);
      chk("seen_cleared", 32'(pass), 0);
      step(1'b0, 1'b0, '0, 3'b110);
      chk("err_fail", 32'(fail), 1);
      chk("err_done", 32'(done), 1);
      chk("err_mask", 32'(fail_mask), 32'b110);
      chk("err_ffi", 32'(first_fail_idx), 1);

      // Error with every ready high in the same cycle is still FAIL.
      step(1'b0, 1'b1, '0, '0);
      chk("clr_keeps_mask", 32'(fail_mask), 32'b110);
      step(1'b1, 1'b0, '0, '0);
      step(1'b0, 1'b0, 3'b111, 3'b001);
      chk("prio_fail", 32'(fail), 1);
      chk("prio_pass", 32'(pass), 0);
      chk("prio_ffi", 32'(first_fail_idx), 0);
      chk("prio_mask", 32'(fail_mask), 32'b001);

      // clear during RUN aborts silently and keeps the count.
      step(1'b0, 1'b1, '0, '0);
      step(1'b1, 1'b0, '0, '0);
      idle(3);
      step(1'b0, 1'b1, '0, '0);
      chk("abort_done", 32'(done), 0);
      chk("abort_fail", 32'(fail), 0);
      chk("abort_cnt", 32'(cycle_count), 3);

      // Watchdog: no ready at all.
      step(1'b1, 1'b0, '0, '0);
      idle(15);
      chk("wd_cnt15", 32'(cycle_count), 15);
      chk("wd_not_yet", 32'(timeout), 0);
      idle(1);
`ifdef TEST_AGGREGATOR_WATCHDOG_EN
      chk("wd_timeout", 32'(timeout), 1);
      chk("wd_done", 32'(done), 1);
      chk("wd_cnt16", 32'(cycle_count), 16);
`else
      chk("nowd_timeout", 32'(timeout), 0);
      chk("nowd_done", 32'(done), 0);
      chk("nowd_cnt16", 32'(cycle_count), 16);
      idle(20);
      chk("nowd_sat", 32'(cycle_count), CNT_MAX);
      chk("nowd_still_run", 32'(pass | fail | timeout), 0);
`endif

      // Asynchronous reset at cycle 7 of a run.
      step(1'b0, 1'b1, '0, '0);
      step(1'b1, 1'b0, '0, '0);
      step(1'b0, 1'b0, '0, 3'b010);
      step(1'b0, 1'b1, '0, '0);
      step(1'b1, 1'b0, '0, '0);
      idle(7);
      chk("pre_rst_cnt", 32'(cycle_count), 7);
      #1 reset = 1'b0;
      #1 chk_all_zero("async_rst");
      @(posedge clk);
      #1 reset = 1'b1;
      step(1'b1, 1'b0, '0, '0);
      chk("post_rst_cnt0", 32'(cycle_count), 0);
      idle(1);
      chk("post_rst_cnt1", 32'(cycle_count), 1);

      // Random traffic, with the occasional mid-cycle reset.
      for (int k = 0; k < 3000; k++) begin
         logic s, c;
         logic [NUM_CH-1:0] r, e;
         s = ($urandom_range(0, 5) == 0);
         c = ($urandom_range(0, 39) == 0);
         for (int b = 0; b < NUM_CH; b++) begin
            r[b] = ($urandom_range(0, 7) == 0);
            e[b] = ($urandom_range(0, 59) == 0);
         end
         step(s, c, r, e);
         if ($urandom_range(0, 499) == 0) begin
            #2 reset = 1'b0;
            @(posedge clk);
            #1 reset = 1'b1;
         end
      end

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/test_aggregator.md
TEST_AGGREGATOR -- requirements
Module: test_aggregator

Interface
REQ-001 Parameter NUM_CH, default 3: number of sub-bench channels; legal range 1..32.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: watchdog limit in cycles while running; must be at least 2.
REQ-003 Parameter CNT_W, default 32: width of cycle_count; must satisfy 2**CNT_W > TIMEOUT_CYCLES.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle pulse; arms a run.
REQ-007 clear  in  1  returns the block to IDLE from any state.
REQ-008 ready  in  NUM_CH  per-channel "sub-bench finished OK" level or pulse.
REQ-009 error  in  NUM_CH  per-channel "sub-bench failed" level or pulse.
REQ-010 done  out  1  single-cycle pulse on the cycle the block enters PASS, FAIL or TMO.
REQ-011 pass / fail / timeout  out  1 each  one-hot verdict; held while in the matching terminal state.
REQ-012 fail_mask  out  NUM_CH  sticky record of every channel whose error was seen during the run.
REQ-013 first_fail_idx  out  $clog2(NUM_CH) (min 1)  channel index of the first failure.
REQ-014 cycle_count  out  CNT_W  cycles spent in RUN.

Function
REQ-015 FSM states: IDLE, RUN, PASS, FAIL, TMO.
REQ-016 Transitions:
- IDLE->RUN on start.
- RUN->FAIL when any error bit is 1.
- RUN->PASS when every channel has ready_seen or ready this cycle, and no error bit is 1.
- RUN->TMO per REQ-021.
REQ-017 Priority within one RUN cycle: FAIL over PASS over TMO.
REQ-018 ready_seen is a per-channel sticky bit, set in RUN and cleared on entry to RUN.
- Pulse-style and level-style ready both count.
REQ-019 fail_mask ORs in the error bits during RUN only; error and ready are ignored in IDLE and in terminal states.
REQ-020 first_fail_idx captures the lowest-numbered asserted error bit in the RUN->FAIL cycle; it holds until the next entry to RUN, which resets it to 0.
REQ-021 cycle_count:
- Cleared to 0 on entry to RUN.
- Increments by 1 each RUN cycle; frozen in terminal states.
- Timeout fires when cycle_count == TIMEOUT_CYCLES-1 and neither FAIL nor PASS applies.
REQ-022 done asserts for exactly one cycle, on the first cycle the block is in a terminal state. Verdict outputs are registered: 1-cycle latency from the deciding inputs.
REQ-023 start outside IDLE is ignored; start and clear together resolve to clear.
REQ-024 clear in RUN aborts to IDLE: no done pulse, all verdicts 0. fail_mask and cycle_count keep their values until the next start.
REQ-025 A channel that is already ready_seen and later raises error still causes FAIL.

Reset
REQ-026 On reset low, asynchronously force:
- state = IDLE.
- done, pass, fail, timeout = 0.
- fail_mask = 0, first_fail_idx = 0, cycle_count = 0.
- all ready_seen = 0.
REQ-027 Reset mid-run discards the run; no verdict or done pulse is produced.

Configuration
REQ-028 Macro TEST_AGGREGATOR_WATCHDOG_EN:
- Defined: the watchdog and the TMO state behave as in REQ-021.
- Undefined: TMO is unreachable, timeout is tied to 0, and cycle_count still counts but saturates at all-ones.

Structure
REQ-029 Package test_aggregator_pkg holds:
- the state enum type;
- a verdict enum (NONE, PASS, FAIL, TMO);
- a function for the width of first_fail_idx.
REQ-030 Sub-module prio_enc_lsb, parameterised by width: returns the index of the lowest set bit plus a valid flag. It drives first_fail_idx.

Verification
REQ-031 NUM_CH=3, start, then ready pulses on ch0/ch1/ch2 at cycles 2/5/9 -> done and pass in the cycle after the ch2 pulse; fail_mask=000.
REQ-032 NUM_CH=3, ready ch0, then error ch2 and ch1 in the same cycle -> FAIL; fail_mask=110; first_fail_idx=1.
REQ-033 Same cycle: error on ch0 and all ready bits 1 -> FAIL, not PASS.
REQ-034 Watchdog defined, TIMEOUT_CYCLES=16, no ready -> done and timeout in the cycle after cycle_count=15. Watchdog undefined -> the block stays in RUN.
REQ-035 Reset low during RUN at cycle 7 -> all outputs 0 immediately (asynchronously), no done pulse. Subsequent start -> cycle_count restarts at 0.
REQ-036 clear in RUN -> IDLE, no done. start while in PASS -> ignored; clear then start -> new run with ready_seen cleared.
